// File: rtl/lnic_net_pkg.sv
// Shared network RX types: beat widths, the stored beat layout and the
// ACCEPT/DROP state encoding used by the receive buffer.
package lnic_net_pkg;

  localparam int unsigned NET_DATA_W = 64;
  localparam int unsigned NET_KEEP_W = 8;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic [NET_DATA_W-1:0] data;
    logic [NET_KEEP_W-1:0] keep;
    logic                  last;
  } net_beat_t;

  localparam int unsigned NET_BEAT_W = $bits(net_beat_t);

endpackage

// File: rtl/lnic_rx_mem.sv
// Beat storage: one write port, one combinational read port, contents not reset.
module lnic_rx_mem
  import lnic_net_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  net_beat_t       wr_beat_i,
  input  logic [AW-1:0]   rd_addr_i,
  output net_beat_t       rd_beat_c_o
);

  net_beat_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_beat_i;
    end
  end

  assign rd_beat_c_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lnic_net_rx_buffer.sv
// Store-and-forward network RX buffer: frames become visible only once their
// last beat is stored; frames that overflow the buffer are dropped and counted.
module lnic_net_rx_buffer
  import lnic_net_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  net_in_valid,
  input  logic [NET_DATA_W-1:0] net_in_bits_data,
  input  logic [NET_KEEP_W-1:0] net_in_bits_keep,
  input  logic                  net_in_bits_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NET_DATA_W-1:0] out_bits_data,
  output logic [NET_KEEP_W-1:0] out_bits_keep,
  output logic                  out_bits_last,
  output logic [31:0]           drop_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CNT_W = 32;

  rx_state_e          state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;
  logic               full;
  logic               wr_en;
  logic               drop_inc;
  net_beat_t          wr_beat;
  net_beat_t          rd_beat;

  // Space is judged against the registered read pointer only.
  assign full      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign out_valid = (rd_ptr_q != commit_ptr_q);

  assign wr_beat.data = net_in_bits_data;
  assign wr_beat.keep = net_in_bits_keep;
  assign wr_beat.last = net_in_bits_last;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_count_d = drop_count_q;
    wr_en        = 1'b0;
    drop_inc     = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (net_in_valid) begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (net_in_bits_last) begin
              commit_ptr_d = wr_ptr_q + PW'(1);
            end
          end else begin
            // Overflow: throw away the partial frame and skip the rest of it.
            wr_ptr_d = commit_ptr_q;
            if (net_in_bits_last) begin
              drop_inc = 1'b1;
            end else begin
              state_d = DROP;
            end
          end
        end
      end
      DROP: begin
        if (net_in_valid && net_in_bits_last) begin
          drop_inc = 1'b1;
          state_d  = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase

    if (drop_inc && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end

    if (out_valid && out_ready) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (reset) begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_count_q <= drop_count_d;
    end
  end

  lnic_rx_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock       (clock),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_ptr_q[AW-1:0]),
    .wr_beat_i   (wr_beat),
    .rd_addr_i   (rd_ptr_q[AW-1:0]),
    .rd_beat_c_o (rd_beat)
  );

  assign out_bits_data = rd_beat.data;
  assign out_bits_keep = rd_beat.keep;
  assign out_bits_last = rd_beat.last;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_lnic_net_rx_buffer.sv
// Scoreboard bench for lnic_net_rx_buffer: stimulus queues expected beats,
// a negedge monitor compares whatever the buffer presents.
module tb_lnic_net_rx_buffer;
  import lnic_net_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        net_in_valid = 1'b0;
  logic [63:0] net_in_bits_data = '0;
  logic [7:0]  net_in_bits_keep = '0;
  logic        net_in_bits_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_bits_data;
  logic [7:0]  out_bits_keep;
  logic        out_bits_last;
  logic [31:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  net_beat_t exp_q[$];

  always #5 clock = ~clock;

  lnic_net_rx_buffer #(.DEPTH(64)) dut (
    .clock            (clock),
    .reset            (reset),
    .net_in_valid     (net_in_valid),
    .net_in_bits_data (net_in_bits_data),
    .net_in_bits_keep (net_in_bits_keep),
    .net_in_bits_last (net_in_bits_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_bits_data    (out_bits_data),
    .out_bits_keep    (out_bits_keep),
    .out_bits_last    (out_bits_last),
    .drop_count       (drop_count)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Front of the queue must be presented; it is retired only on a handshake.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data %0h required no output", out_bits_data);
      end else begin
        check("out_beat", 128'({out_bits_data, out_bits_keep, out_bits_last}), 128'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input bit push);
    net_beat_t b;
    net_in_valid     = 1'b1;
    net_in_bits_data = d;
    net_in_bits_keep = k;
    net_in_bits_last = l;
    b.data = d;
    b.keep = k;
    b.last = l;
    if (push) exp_q.push_back(b);
    step();
    net_in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] tag, input int len, input bit push);
    for (int i = 0; i < len; i++) begin
      send_beat({tag, 56'(i)}, 8'hFF, (i == len - 1), push);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    net_in_valid = 1'b0;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_drop_count", 128'(drop_count), 128'(0));
  endtask

  task automatic drain(input string name, input bit toggle);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      out_ready = toggle ? c[0] : 1'b1;
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    check(name, 128'(exp_q.size()), 128'(0));
    check({name, "_idle"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    do_reset();

    // 3-beat frame, out_valid one cycle after the last write
    out_ready = 1'b1;
    send_beat(64'h11, 8'hFF, 1'b0, 1'b1);
    check("sf_hidden_b1", 128'(out_valid), 128'(0));
    send_beat(64'h22, 8'hFF, 1'b0, 1'b1);
    check("sf_hidden_b2", 128'(out_valid), 128'(0));
    send_beat(64'h33, 8'h0F, 1'b1, 1'b1);
    check("sf_latency", 128'(out_valid), 128'(1));
    drain("drain_3beat", 1'b0);
    check("drop_3beat", 128'(drop_count), 128'(0));

    // 40 then 30 beats with no reader: second frame overflows
    do_reset();
    out_ready = 1'b0;
    send_frame(8'hA0, 40, 1'b1);
    send_frame(8'hA1, 30, 1'b0);
    check("drop_after_30", 128'(drop_count), 128'(1));
    send_frame(8'hA2, 24, 1'b1);
    check("drop_after_24", 128'(drop_count), 128'(1));
    drain("drain_40_24", 1'b0);

    // single 65-beat frame with reader active: dropped, buffer still accepts
    do_reset();
    out_ready = 1'b1;
    send_frame(8'hB0, 65, 1'b0);
    check("drop_65", 128'(drop_count), 128'(1));
    send_frame(8'hB1, 2, 1'b1);
    drain("drain_after_65", 1'b0);

    // out_ready toggling while two frames arrive
    do_reset();
    for (int i = 0; i < 5; i++) begin
      out_ready = (i % 2 == 0);
      send_beat({8'hC0, 56'(i)}, 8'(8'h1 << i), (i == 4), 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      out_ready = (i % 2 == 0);
      send_beat({8'hC1, 56'(i)}, 8'hF0, (i == 2), 1'b1);
    end
    drain("drain_toggle", 1'b1);
    check("drop_toggle", 128'(drop_count), 128'(0));

    // reset on beat 2 of a 4-beat frame
    do_reset();
    out_ready = 1'b1;
    send_beat(64'hD0, 8'hFF, 1'b0, 1'b0);
    reset            = 1'b1;
    net_in_valid     = 1'b1;
    net_in_bits_data = 64'hD1;
    net_in_bits_keep = 8'hFF;
    net_in_bits_last = 1'b0;
    step();
    reset        = 1'b0;
    net_in_valid = 1'b0;
    check("midreset_out_valid", 128'(out_valid), 128'(0));
    check("midreset_drop", 128'(drop_count), 128'(0));
    send_beat(64'hD2, 8'hFF, 1'b0, 1'b1);
    send_beat(64'hD3, 8'h3F, 1'b1, 1'b1);
    drain("drain_midreset", 1'b0);

    // drop counter saturation
    do_reset();
    out_ready = 1'b1;
    force dut.drop_count_q = 32'hFFFF_FFFE;
    @(negedge clock);
    release dut.drop_count_q;
    step();
    send_frame(8'hE0, 65, 1'b0);
    check("sat_first", 128'(drop_count), 128'(32'hFFFF_FFFF));
    send_frame(8'hE1, 65, 1'b0);
    check("sat_hold", 128'(drop_count), 128'(32'hFFFF_FFFF));
    drain("drain_sat", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
